// File: rtl/branch_hazard_scoreboard_pkg.sv
// branch_hazard_scoreboard_pkg: shared write-register encodings and scoreboard entry layout
package branch_hazard_scoreboard_pkg;
  localparam logic [1:0] WREG_SEL_75  = 2'b00;
  localparam logic [1:0] WREG_SEL_42  = 2'b01;
  localparam logic [1:0] WREG_SEL_108 = 2'b10;
  localparam logic [1:0] WREG_SEL_R7  = 2'b11;
  localparam logic [2:0] RETURN_ADDR_REG = 3'h7;
  localparam int REG_W = 3;
  typedef struct packed {
    logic             v;
    logic             wen;
    logic [REG_W-1:0] rd;
    logic             ld;
  } sb_entry_t;
endpackage

// File: rtl/branch_hazard_scoreboard_if.sv
// branch_hazard_scoreboard_if: decode-side request and stall/bubble response bundle
interface branch_hazard_scoreboard_if;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [2:0]  dec_rs;
  logic        dec_reads_rs;
  logic        dec_regwrite;
  logic [1:0]  dec_wregsel;
  logic        dec_is_load;
  logic        pipe_hold;
  logic        flush;
  logic        stall;
  logic        bubble;
  modport master (
    output dec_valid, dec_instr, dec_rs, dec_reads_rs, dec_regwrite, dec_wregsel, dec_is_load,
           pipe_hold, flush,
    input  stall, bubble
  );
  modport slave (
    input  dec_valid, dec_instr, dec_rs, dec_reads_rs, dec_regwrite, dec_wregsel, dec_is_load,
           pipe_hold, flush,
    output stall, bubble
  );
endinterface

// File: rtl/branch_hazard_scoreboard_wreg_decode.sv
// branch_hazard_scoreboard_wreg_decode: maps instruction word and write-select to destination register
module branch_hazard_scoreboard_wreg_decode
  import branch_hazard_scoreboard_pkg::*;
(
  input  logic [15:0]      instr,
  input  logic [1:0]       wregsel,
  output logic [REG_W-1:0] rd
);
  logic unused_bits;
  assign unused_bits = ^{instr[15:11], instr[1:0]};
  always_comb
    rd = wregsel == WREG_SEL_75  ? instr[7:5]  :
         wregsel == WREG_SEL_42  ? instr[4:2]  :
         wregsel == WREG_SEL_108 ? instr[10:8] : RETURN_ADDR_REG;
endmodule

// File: rtl/branch_hazard_scoreboard.sv
// branch_hazard_scoreboard: stall controller for decode-resolved branches, with stall counter and watchdog
module branch_hazard_scoreboard
  import branch_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int FWD_EN   = 1,
  parameter int WD_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_hazard_scoreboard_if.slave bus,
  output logic [15:0]              stall_cnt,
  output logic                     hazard_err
);
  sb_entry_t        e [1:DEPTH];
  sb_entry_t        new_e;
  logic [REG_W-1:0] rd;
  logic [DEPTH:1]   match;
  logic             hazard;
  logic [2:0]       run_cnt;
  logic [2:0]       run_nxt;
  branch_hazard_scoreboard_wreg_decode u_wreg_decode (
    .instr  (bus.dec_instr),
    .wregsel(bus.dec_wregsel),
    .rd     (rd)
  );
  // with forwarding only an EX-stage writer or a load still in MEM is unresolvable in decode
  always_comb begin
    match = '0;
    for (int k = 1; k <= DEPTH; k++) match[k] = e[k].v & e[k].wen & (e[k].rd == bus.dec_rs);
    hazard  = FWD_EN != 0 ? match[1] | (match[2] & e[2].ld) : |match;
    new_e   = '{v: 1'b1, wen: bus.dec_regwrite, rd: rd, ld: bus.dec_is_load};
    run_nxt = &run_cnt ? run_cnt : run_cnt + 3'd1;
  end
  assign bus.stall  = bus.dec_valid & bus.dec_reads_rs & hazard & ~bus.flush;
  assign bus.bubble = bus.stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) e[k] <= '0;
      stall_cnt  <= '0;
      run_cnt    <= '0;
      hazard_err <= 1'b0;
    end else if (!bus.pipe_hold) begin
      e[1] <= bus.dec_valid & ~bus.stall & ~bus.flush ? new_e : '0;
      for (int k = 2; k <= DEPTH; k++) e[k] <= e[k-1];
      stall_cnt  <= bus.stall & !(&stall_cnt) ? stall_cnt + 16'd1 : stall_cnt;
      run_cnt    <= bus.stall ? run_nxt : '0;
      hazard_err <= hazard_err | (bus.stall & (int'(run_nxt) >= WD_LIMIT));
    end
  end
endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// tb_branch_hazard_scoreboard: directed vectors with a queued expectation scoreboard
module tb_branch_hazard_scoreboard;
  typedef struct {
    int          sel;
    logic        st;
    logic [15:0] cnt;
    logic        err;
    string       nm;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0, rdrs = 1'b0, rw = 1'b0, ld = 1'b0, hold = 1'b0, fl = 1'b0;
  logic [15:0] instr = '0;
  logic [2:0]  rs = '0;
  logic [1:0]  wsel = '0;
  int          sel = 0, cur = 0;
  int          tests = 0, failed = 0;
  exp_t        q[$];
  exp_t        x;
  logic        m_st, m_bb, m_err;
  logic [15:0] m_cnt;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic        err_a, err_b, err_c;
  branch_hazard_scoreboard_if ia ();
  branch_hazard_scoreboard_if ib ();
  branch_hazard_scoreboard_if ic ();
  assign ia.dec_valid = v && sel == 0;
  assign ib.dec_valid = v && sel == 1;
  assign ic.dec_valid = v && sel == 2;
  assign {ia.dec_instr, ib.dec_instr, ic.dec_instr} = {3{instr}};
  assign {ia.dec_rs, ib.dec_rs, ic.dec_rs} = {3{rs}};
  assign {ia.dec_reads_rs, ib.dec_reads_rs, ic.dec_reads_rs} = {3{rdrs}};
  assign {ia.dec_regwrite, ib.dec_regwrite, ic.dec_regwrite} = {3{rw}};
  assign {ia.dec_wregsel, ib.dec_wregsel, ic.dec_wregsel} = {3{wsel}};
  assign {ia.dec_is_load, ib.dec_is_load, ic.dec_is_load} = {3{ld}};
  assign {ia.pipe_hold, ib.pipe_hold, ic.pipe_hold} = {3{hold}};
  assign {ia.flush, ib.flush, ic.flush} = {3{fl}};
  branch_hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .WD_LIMIT(4)) da (
    .clk(clk), .rst_n(rst_n), .bus(ia), .stall_cnt(cnt_a), .hazard_err(err_a));
  branch_hazard_scoreboard #(.DEPTH(3), .FWD_EN(0), .WD_LIMIT(4)) db (
    .clk(clk), .rst_n(rst_n), .bus(ib), .stall_cnt(cnt_b), .hazard_err(err_b));
  branch_hazard_scoreboard #(.DEPTH(4), .FWD_EN(0), .WD_LIMIT(4)) dc (
    .clk(clk), .rst_n(rst_n), .bus(ic), .stall_cnt(cnt_c), .hazard_err(err_c));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      x = q.pop_front();
      m_st  = x.sel == 0 ? ia.stall  : x.sel == 1 ? ib.stall  : ic.stall;
      m_bb  = x.sel == 0 ? ia.bubble : x.sel == 1 ? ib.bubble : ic.bubble;
      m_cnt = x.sel == 0 ? cnt_a     : x.sel == 1 ? cnt_b     : cnt_c;
      m_err = x.sel == 0 ? err_a     : x.sel == 1 ? err_b     : err_c;
      tests++;
      if ({m_st, m_bb, m_cnt, m_err} !== {x.st, x.st, x.cnt, x.err}) begin
        failed++;
        $display("FAIL %s dut%0d: got stall=%b bubble=%b cnt=%0d err=%b, want stall=%b bubble=%b cnt=%0d err=%b",
                 x.nm, x.sel, m_st, m_bb, m_cnt, m_err, x.st, x.st, x.cnt, x.err);
      end
    end
  end
  task automatic step(input string nm, input logic vv, input logic [15:0] ii, input logic [2:0] rr,
                      input logic rd_rs, input logic rww, input logic [1:0] ws, input logic lw,
                      input logic hh, input logic ff, input logic est, input logic [15:0] ecnt,
                      input logic eerr);
    @(posedge clk);
    #1;
    sel = cur; v = vv; instr = ii; rs = rr; rdrs = rd_rs; rw = rww; wsel = ws; ld = lw; hold = hh; fl = ff;
    q.push_back('{sel: cur, st: est, cnt: ecnt, err: eerr, nm: nm});
  endtask
  task automatic idle(input string nm, input logic [15:0] ecnt, input logic eerr);
    step(nm, 0, 16'h0, 3'd0, 0, 0, 2'd0, 0, 0, 0, 0, ecnt, eerr);
  endtask
  task automatic rst_step(input string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.push_back('{sel: cur, st: 1'b0, cnt: 16'd0, err: 1'b0, nm: nm});
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    rst_step("reset");
    cur = 0;
    idle("after_reset", 0, 0);
    step("add_r3", 1, 16'h0060, 3'd0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    step("beqz_alu_stall", 1, 16'h0000, 3'd3, 1, 0, 2'd0, 0, 0, 0, 1, 0, 0);
    step("beqz_alu_issue", 1, 16'h0000, 3'd3, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0);
    idle("alu_cnt", 1, 0);
    step("ld_r2", 1, 16'h0008, 3'd0, 0, 1, 2'd1, 1, 0, 0, 0, 1, 0);
    step("jr_ld_stall1", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    step("jr_ld_stall2", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 1, 2, 0);
    step("jr_ld_issue", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 0, 3, 0);
    idle("ld_cnt", 3, 0);
    step("add_r4", 1, 16'h0080, 3'd0, 0, 1, 2'd0, 0, 0, 0, 0, 3, 0);
    step("beqz_r5_norm", 1, 16'h0000, 3'd5, 1, 0, 2'd0, 0, 0, 0, 0, 3, 0);
    step("r3_nowen", 1, 16'h0060, 3'd0, 0, 0, 2'd0, 0, 0, 0, 0, 3, 0);
    step("beqz_r3_nowen", 1, 16'h0000, 3'd3, 1, 0, 2'd0, 0, 0, 0, 0, 3, 0);
    step("wr_r6_sel10", 1, 16'h0600, 3'd0, 0, 1, 2'd2, 0, 0, 0, 0, 3, 0);
    step("beqz_r6_stall", 1, 16'h0000, 3'd6, 1, 0, 2'd0, 0, 0, 0, 1, 3, 0);
    step("beqz_r6_issue", 1, 16'h0000, 3'd6, 1, 0, 2'd0, 0, 0, 0, 0, 4, 0);
    step("ld_r2_b", 1, 16'h0008, 3'd0, 0, 1, 2'd1, 1, 0, 0, 0, 4, 0);
    step("hold_stall0", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 1, 4, 0);
    step("hold_1", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 1, 0, 1, 5, 0);
    step("hold_2", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 1, 0, 1, 5, 0);
    step("hold_3", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 1, 0, 1, 5, 0);
    step("hold_release", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 1, 5, 0);
    step("hold_issue", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 0, 6, 0);
    idle("hold_cnt", 6, 0);
    step("add_r3_f", 1, 16'h0060, 3'd0, 0, 1, 2'd0, 0, 0, 0, 0, 6, 0);
    step("flush_wins", 1, 16'h0000, 3'd3, 1, 1, 2'd3, 0, 0, 1, 0, 6, 0);
    step("flush_bubble", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 0, 6, 0);
    step("flush_hold", 1, 16'h00a0, 3'd0, 0, 1, 2'd0, 0, 1, 1, 0, 6, 0);
    step("flush_hold_nowr", 1, 16'h0000, 3'd5, 1, 0, 2'd0, 0, 0, 0, 0, 6, 0);
    step("ld_r2_c", 1, 16'h0008, 3'd0, 0, 1, 2'd1, 1, 0, 0, 0, 6, 0);
    step("jr_before_rst", 1, 16'h0000, 3'd2, 1, 0, 2'd0, 0, 0, 0, 1, 6, 0);
    rst_step("rst_mid_stall");
    idle("post_rst", 0, 0);
    cur = 1;
    step("jal_r7", 1, 16'h0000, 3'd0, 0, 1, 2'd3, 0, 0, 0, 0, 0, 0);
    step("nofwd_stall1", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 0, 0);
    step("nofwd_stall2", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    step("nofwd_stall3", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 2, 0);
    step("nofwd_issue", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 0, 3, 0);
    idle("nofwd_noerr", 3, 0);
    cur = 2;
    step("wd_jal", 1, 16'h0000, 3'd0, 0, 1, 2'd3, 0, 0, 0, 0, 0, 0);
    step("wd_stall1", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 0, 0);
    step("wd_stall2", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    step("wd_hold", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 1, 0, 1, 2, 0);
    step("wd_stall3", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 2, 0);
    step("wd_stall4", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 1, 3, 0);
    step("wd_set", 1, 16'h0000, 3'd7, 1, 0, 2'd0, 0, 0, 0, 0, 4, 1);
    idle("wd_sticky1", 4, 1);
    idle("wd_sticky2", 4, 1);
    rst_step("wd_rst");
    idle("wd_post_rst", 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/branch_hazard_scoreboard.md
Name: branch_hazard_scoreboard

Overview:
- Stall controller for decode-resolved branches and jumps (JR/JALR/BEQZ class).
- Keeps a shift-register scoreboard of in-flight register writers (EX, MEM, WB).
- Decides when the decode instruction must stall, and inserts bubbles into EX.
- Keeps a stall performance counter and a sticky deadlock watchdog.
- Sits between decode and the ID/EX pipeline register; drives the PC/IF-ID hold and the EX bubble mux.

Parameters:
- DEPTH, 3, number of scoreboard slots; slot 1 = EX, slot 2 = MEM, slot 3 = WB.
- FWD_EN, 1, 1 = EX/MEM forwarding into decode exists; 0 = only the register file supplies operands.
- WD_LIMIT, 4, consecutive stall cycles allowed before hazard_err is set.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- dec_valid  in  1  decode holds a valid instruction
- dec_instr  in  16  decode instruction word
- dec_rs  in  3  register the decode instruction must read early
- dec_reads_rs  in  1  decode instruction is a branch/jump that needs dec_rs in decode
- dec_regwrite  in  1  decode instruction writes a register
- dec_wregsel  in  2  write-register select: 00=[7:5], 01=[4:2], 10=[10:8], 11=R7
- dec_is_load  in  1  decode instruction is LD
- pipe_hold  in  1  memory stall; whole pipeline frozen this cycle
- flush  in  1  taken branch/jump; decode instruction is squashed
- stall  out  1  hold PC and IF/ID
- bubble  out  1  inject NOP into ID/EX
- stall_cnt  out  16  saturating count of stall cycles
- hazard_err  out  1  sticky watchdog flag

Behaviour:
- Each slot k holds {v, wen, rd[2:0], ld}.
- rd of a new entry comes from dec_wregsel decoding of dec_instr.
- R0 is an ordinary register; it gets no special case.
- Match(k) = e[k].v & e[k].wen & (e[k].rd == dec_rs).
- When FWD_EN=1, hazard = Match(1) | (Match(2) & e[2].ld).
- When FWD_EN=0, hazard = OR of Match(k) over k = 1..DEPTH.
- stall = dec_valid & dec_reads_rs & hazard & ~flush.
- stall and bubble are combinational. bubble = stall.
- flush has priority over stall: a squashed instruction never stalls.
- Scoreboard update happens on the clock edge when pipe_hold=0:
  - e[k+1] <= e[k] for k = 1..DEPTH-1; e[DEPTH] retires.
  - e[1] <= {1, dec_regwrite, rd, dec_is_load} when dec_valid & ~stall & ~flush.
  - Otherwise e[1] <= invalid.
- When pipe_hold=1, all state and counters hold. stall is still driven from current state.
- stall_cnt increments when stall & ~pipe_hold, and saturates at 16'hFFFF.
- run_cnt (internal, 3 bits, saturating) counts consecutive stall & ~pipe_hold cycles.
  - It clears on any cycle with stall=0.
  - hazard_err is set when run_cnt reaches WD_LIMIT.
  - hazard_err stays set until reset.
- Latency:
  - One dependent ALU writer one slot ahead: 1 stall cycle (FWD_EN=1).
  - Load one slot ahead: 2 stall cycles.
  - With FWD_EN=0, the stall lasts until the writer leaves slot DEPTH.
- Reset (async, rst_n=0):
  - All slots invalid; stall_cnt = 0; run_cnt = 0; hazard_err = 0.
  - stall = 0 and bubble = 0 while in reset.
  - Reset asserted mid-stall drops stall immediately.
- Simultaneous events:
  - flush & pipe_hold: freeze wins; the entry is not written.
  - The flush must be re-presented by the pipeline.

Decomposition:
- Shared package holds:
  - WREG_SEL_* encodings (00/01/10/11).
  - RETURN_ADDR_REG = 3'h7.
  - The scoreboard entry struct/field widths.
- Sub-module wreg_decode is the combinational map (instr, wregsel) -> rd[2:0].
- wreg_decode is reused by other hazard logic.

Test Plan:
- ADD R3 writes ([7:5]=3, sel 00), next cycle BEQZ dec_rs=3, FWD_EN=1 -> stall=1 for exactly 1 cycle, bubble=1 that cycle, stall_cnt=1.
- LD R2 (sel 01, [4:2]=2), next cycle JR rs=2 -> stall 2 consecutive cycles, then issue, stall_cnt=2.
- JAL (sel 11 -> R7) followed by JR R7, FWD_EN=0, DEPTH=3 -> 3 stall cycles.
- Writer with wen=0 or different rd (R4 vs dec_rs=5) -> stall=0 in all cycles.
- Load hazard with pipe_hold=1 for 3 cycles mid-stall -> stall stays 1, scoreboard frozen, stall_cnt unchanged during the hold, then 1 more stall cycle.
- Hazard present with flush=1 -> stall=0 and a bubble enters slot 1. Separately, force dec_reads_rs and a matching slot by holding the pipe so the stall persists for 4 non-held cycles (WD_LIMIT=4) -> hazard_err=1 and sticky. Then rst_n=0 -> all outputs 0 immediately.
